dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
Data-bus responder that services dbus_req_t requests from the memory stage and returns dbus_resp_t after a fixed, parameterised latency. It holds a byte-strobed 64-bit-word SRAM model and serves loads and stores of 1, 2, 4 or 8 bytes. It sits on the core's dbus port in place of the external memory, for simulation and small SoC builds. Per the team's bus convention, the initiator holds its request stable until data_ok.

Parameters:
DEPTH, 4096, number of 64-bit words in the array (power of two)
BASE, 64'h8000_0000, byte address of word 0
LATENCY, 2, cycles from acceptance to data_ok (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
dreq  input  dbus_req_t  request: valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]
dresp  output  dbus_resp_t  response: addr_ok, data_ok, data[63:0]
err  output  1  one-cycle pulse, coincident with data_ok, for an out-of-range or misaligned access

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, err=0.
  - FSM goes to IDLE and the counter to 0.
  - Array contents are not reset.
  - Reset mid-transaction aborts it: no data_ok, and a pending write is dropped.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If dreq.valid, then addr_ok=1 combinationally in that cycle (cycle T).
  - Latch addr, size, strobe, data and is_write (is_write = strobe != 0).
  - Load cnt=LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise BUSY.
- BUSY: decrement cnt each cycle. When cnt reaches 1, go to RESP.
- RESP:
  - data_ok=1 for exactly one cycle, at cycle T+LATENCY.
  - dresp.data is valid in this same cycle.
  - Next state is IDLE.
- addr_ok is 0 in BUSY and RESP.
- Back-to-back rule:
  - A request present during the RESP cycle is the same transaction and is not re-accepted.
  - The earliest next acceptance is cycle T+LATENCY+1.
  - Maximum throughput is one access per LATENCY+1 cycles.
- dreq.valid may drop after acceptance. The accepted transaction still completes and a write still commits. Behaviour uses latched fields only.
- Address decode:
  - off = addr - BASE.
  - idx = off[log2(DEPTH)+2:3]; byte offset = addr[2:0].
  - In range iff addr >= BASE and off < DEPTH*8.
- Alignment: aligned iff addr[2:0] mod size-bytes == 0. Size bytes: MSIZE1=1, MSIZE2=2, MSIZE4=4, MSIZE8=8.
- Fault = out of range or misaligned. On fault:
  - Read returns 64'h0.
  - Write is discarded.
  - err pulses with data_ok.
- Read:
  - dresp.data returns the full aligned 64-bit word at idx, unshifted. The initiator extracts and sign-extends.
  - The word is registered from the array at the edge entering RESP.
  - A read observes all writes whose RESP cycle is earlier.
- Write:
  - Bytes where strobe[i]=1 are written as array[idx][8i+7:8i] <= data[8i+7:8i], at the clock edge ending the RESP cycle.
  - Strobe is taken as given (already lane-shifted by the initiator). No size/strobe consistency check beyond alignment.
  - dresp.data=0 for writes.
- dresp.data holds its value outside RESP; the bench checks it only when data_ok=1.

Decomposition:
- Package common (existing): dbus_req_t, dbus_resp_t, msize_t, strobe_t, u64.
- Add to common: a function msize_bytes(msize_t) and a localparam type for the FSM state enum.
- One sub-module: dbus_sram_array, DEPTH x 64-bit storage.
  - One read port: combinational index, registered output under an enable.
  - One byte-strobed write port.

Test Plan:
- Load at reset exit: preload array[0]=64'h1122334455667788; LATENCY=2; dreq valid, addr=0x80000000, size=MSIZE8, strobe=0 at cycle 0 -> addr_ok=1 in cycle 0, data_ok=1 only in cycle 2, data=64'h1122334455667788, err=0.
- Strobed store then load: SW addr=0x80000004, strobe=8'hF0, data=64'hDEADBEEF_00000000 over initial 0; then LD 0x80000000 -> data=64'hDEADBEEF_00000000.
- Back-to-back: two loads issued with valid held continuously -> second addr_ok no earlier than cycle LATENCY+1; exactly two data_ok pulses.
- Faults:
  - Load from 0x7FFFFFF8 -> data=0, err=1 with data_ok.
  - SH to 0x80000003 (misaligned) -> err=1, and a subsequent read of that word is unchanged.
- Reset mid-op: store accepted, reset asserted in cycle 1 -> no data_ok, word unchanged, dresp all zero, next request accepted in the first cycle after reset deasserts.
- LATENCY=1 build: load accepted in cycle 0 -> data_ok in cycle 1; valid dropped in cycle 1 -> transaction still completes normally.

Source files
------------

// File: rtl/dbus_sram_responder_pkg.sv
// Shared dbus types, FSM state encoding and access-decode helpers for the
// SRAM responder.
package dbus_sram_responder_pkg;

  typedef logic [63:0] u64;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    u64      addr;
    msize_t  size;
    strobe_t strobe;
    u64      data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic logic [3:0] msize_bytes(msize_t s);
    case (s)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Fault = outside [base, base+span) or not naturally aligned to the size.
  function automatic logic access_fault(u64 addr, msize_t size, u64 base, u64 span);
    logic [2:0] mask;
    mask = 3'(msize_bytes(size) - 4'd1);
    return (addr < base) || ((addr - base) >= span) || ((addr[2:0] & mask) != 3'd0);
  endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between the memory stage and the responder.
interface dbus_sram_responder_if;
  import dbus_sram_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;

  modport master (output dreq, input  dresp, input  err);
  modport slave  (input  dreq, output dresp, output err);
endinterface

// File: rtl/dbus_sram_responder_array.sv
// DEPTH x 64-bit storage: one registered read port under enable, one
// byte-strobed write port.
module dbus_sram_responder_array
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_idx,
  output u64            rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  strobe_t       wr_strb,
  input  u64            wr_data
);

  logic [7:0][7:0] mem [DEPTH];
  u64 rd_data_d, rd_data_q;

  // rd_clr substitutes zero for faulting reads and for writes.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_clr ? '0 : u64'(mem[rd_idx]);
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_strb[i]) mem[wr_idx][i] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency dbus responder backed by a byte-strobed SRAM model;
// one transaction in flight, IDLE -> (BUSY) -> RESP.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int       DEPTH   = 4096,
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter int       LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_sram_responder_if.slave  bus
);

  localparam int         AW   = $clog2(DEPTH);
  localparam u64         SPAN = u64'(DEPTH) << 3;
  localparam logic [3:0] LAT  = 4'(LATENCY);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  u64         addr_q, addr_d, data_q, data_d;
  msize_t     size_q, size_d;
  strobe_t    strb_q, strb_d;

  logic    accept, cur_fault, cur_write, rd_en, wr_en, resp;
  u64      cur_addr;
  msize_t  cur_size;
  strobe_t cur_strb;
  logic [AW-1:0] cur_idx;
  u64      rd_data;

  assign accept = (state_q == ST_IDLE) && bus.dreq.valid && !reset;
  assign resp   = (state_q == ST_RESP) && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    strb_d  = strb_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: if (bus.dreq.valid) begin
        addr_d  = bus.dreq.addr;
        size_d  = bus.dreq.size;
        strb_d  = bus.dreq.strobe;
        data_d  = bus.dreq.data;
        cnt_d   = LAT - 4'd1;
        state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    size_q <= size_d;
    strb_q <= strb_d;
    data_q <= data_d;
  end

  // With LATENCY==1 the array read happens in the accept cycle, before the
  // request fields are latched, so decode from the live request in IDLE.
  assign cur_addr  = (state_q == ST_IDLE) ? bus.dreq.addr   : addr_q;
  assign cur_size  = (state_q == ST_IDLE) ? bus.dreq.size   : size_q;
  assign cur_strb  = (state_q == ST_IDLE) ? bus.dreq.strobe : strb_q;
  assign cur_idx   = AW'((cur_addr - BASE) >> 3);
  assign cur_fault = access_fault(cur_addr, cur_size, BASE, SPAN);
  assign cur_write = (cur_strb != '0);

  assign rd_en = (accept && (LATENCY == 1)) || ((state_q == ST_BUSY) && (cnt_q == 4'd1));
  assign wr_en = resp && cur_write && !cur_fault;

  dbus_sram_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_clr  (cur_fault || cur_write),
    .rd_idx  (cur_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (cur_idx),
    .wr_strb (strb_q),
    .wr_data (data_q)
  );

  assign bus.dresp.addr_ok = accept;
  assign bus.dresp.data_ok = resp;
  assign bus.dresp.data    = rd_data;
  assign bus.err           = resp && cur_fault;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for two responder builds (LATENCY=2 and LATENCY=1) with a
// transaction-level memory model checked every cycle.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam u64 BASE  = 64'h8000_0000;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_sram_responder_if bus2 ();
  dbus_sram_responder_if bus1 ();

  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2));
  dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  task automatic chk(string nm, u64 got, u64 exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic dbus_req_t mk(u64 a, msize_t s, strobe_t st, u64 d);
    dbus_req_t r;
    r.valid = 1'b1; r.addr = a; r.size = s; r.strobe = st; r.data = d;
    return r;
  endfunction

  task automatic drive(int id, dbus_req_t r);
    if (id == 0) bus2.dreq = r;
    else         bus1.dreq = r;
  endtask

  function automatic dbus_req_t get_req(int id);
    return (id == 0) ? bus2.dreq : bus1.dreq;
  endfunction

  function automatic dbus_resp_t get_resp(int id);
    return (id == 0) ? bus2.dresp : bus1.dresp;
  endfunction

  function automatic logic get_err(int id);
    return (id == 0) ? bus2.err : bus1.err;
  endfunction

  // ---------------- transaction-level model ----------------
  int        lat   [2] = '{2, 1};
  logic      pend  [2] = '{1'b0, 1'b0};
  int        t_acc [2];
  u64        exp_d [2];
  logic      exp_e [2];
  dbus_req_t held  [2];
  u64        mmem  [longint];

  function automatic logic m_fault(u64 a, msize_t s);
    u64 nb;
    case (s)
      MSIZE1:  nb = 1;
      MSIZE2:  nb = 2;
      MSIZE4:  nb = 4;
      default: nb = 8;
    endcase
    return (a < BASE) || (a >= BASE + u64'(DEPTH * 8)) || ((a % nb) != 0);
  endfunction

  function automatic longint m_key(int id, u64 a);
    return longint'(id) * 65536 + longint'((a - BASE) / 8);
  endfunction

  task automatic model_step(int id);
    dbus_req_t  r;
    dbus_resp_t o;
    logic       e;
    longint     k;
    u64         w;
    r = get_req(id);
    o = get_resp(id);
    e = get_err(id);
    if (reset) begin
      chk($sformatf("m%0d_rst_addr_ok", id), u64'(o.addr_ok), 0);
      chk($sformatf("m%0d_rst_data_ok", id), u64'(o.data_ok), 0);
      chk($sformatf("m%0d_rst_err", id), u64'(e), 0);
      pend[id] = 1'b0;
    end else if (pend[id] && cyc == t_acc[id] + lat[id]) begin
      chk($sformatf("m%0d_resp_data_ok", id), u64'(o.data_ok), 1);
      chk($sformatf("m%0d_resp_addr_ok", id), u64'(o.addr_ok), 0);
      chk($sformatf("m%0d_resp_data", id), o.data, exp_d[id]);
      chk($sformatf("m%0d_resp_err", id), u64'(e), u64'(exp_e[id]));
      if (held[id].strobe != 0 && !exp_e[id]) begin
        k = m_key(id, held[id].addr);
        w = mmem.exists(k) ? mmem[k] : 64'h0;
        for (int i = 0; i < 8; i++)
          if (held[id].strobe[i]) w[8*i +: 8] = held[id].data[8*i +: 8];
        mmem[k] = w;
      end
      pend[id] = 1'b0;
    end else if (!pend[id] && r.valid) begin
      chk($sformatf("m%0d_acc_addr_ok", id), u64'(o.addr_ok), 1);
      chk($sformatf("m%0d_acc_data_ok", id), u64'(o.data_ok), 0);
      pend[id]  = 1'b1;
      t_acc[id] = cyc;
      held[id]  = r;
      exp_e[id] = m_fault(r.addr, r.size);
      if (exp_e[id] || r.strobe != 0) exp_d[id] = 64'h0;
      else begin
        k = m_key(id, r.addr);
        exp_d[id] = mmem.exists(k) ? mmem[k] : 64'h0;
      end
    end else begin
      chk($sformatf("m%0d_idle_addr_ok", id), u64'(o.addr_ok), 0);
      chk($sformatf("m%0d_idle_data_ok", id), u64'(o.data_ok), 0);
      chk($sformatf("m%0d_idle_err", id), u64'(e), 0);
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(int id, logic drop, output int acc, output int ok,
                           output u64 rd, output logic e, output u64 d_first);
    int   st;
    logic accd, done;
    dbus_resp_t o;
    st = cyc; acc = -1; ok = -1; rd = '0; e = 1'b0; d_first = '0;
    accd = 1'b0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      o = get_resp(id);
      if (n == 0) d_first = o.data;
      if (o.addr_ok) begin accd = 1'b1; acc = cyc - st; end
      if (o.data_ok) begin done = 1'b1; ok = cyc - st; rd = o.data; e = get_err(id); end
      @(posedge clk); #1;
      if (drop && accd) drive(id, '0);
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL timeout dut%0d: no data_ok within 40 cycles, required one", id);
    end
    drive(id, '0);
  endtask

  task automatic do_acc(int id, u64 a, msize_t s, strobe_t st, u64 d, logic drop,
                        output int acc, output int ok, output u64 rd, output logic e);
    u64 df;
    @(posedge clk); #1;
    drive(id, mk(a, s, st, d));
    wait_done(id, drop, acc, ok, rd, e, df);
  endtask

  initial begin
    int   acc, ok, nok;
    u64   rd, df;
    logic e, sw;
    int   accs[$];
    int   st;

    drive(0, '0); drive(1, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data2", bus2.dresp.data, 0);
    chk("rst_flags2", u64'({bus2.dresp.addr_ok, bus2.dresp.data_ok, bus2.err}), 0);
    chk("rst_data1", bus1.dresp.data, 0);
    reset = 1'b0;

    // preload through the bus
    do_acc(0, BASE,     MSIZE8, 8'hFF, 64'h1122334455667788, 1'b0, acc, ok, rd, e);
    chk("pre_st_data", rd, 0);
    do_acc(0, BASE + 8, MSIZE8, 8'hFF, 64'h0102030405060708, 1'b0, acc, ok, rd, e);
    do_acc(1, BASE,     MSIZE8, 8'hFF, 64'hCAFEF00D12345678, 1'b0, acc, ok, rd, e);

    // load in the first cycle out of reset
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drive(0, mk(BASE, MSIZE8, 8'h00, 64'h0));
    wait_done(0, 1'b0, acc, ok, rd, e, df);
    chk("ldx_acc_cycle", u64'(acc), 0);
    chk("ldx_ok_cycle", u64'(ok), 2);
    chk("ldx_data", rd, 64'h1122334455667788);
    chk("ldx_err", u64'(e), 0);

    // strobed store over a zeroed word
    do_acc(0, BASE,     MSIZE8, 8'hFF, 64'h0, 1'b0, acc, ok, rd, e);
    do_acc(0, BASE + 4, MSIZE4, 8'hF0, 64'hDEADBEEF_00000000, 1'b0, acc, ok, rd, e);
    chk("sw_err", u64'(e), 0);
    do_acc(0, BASE,     MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("sw_ld_data", rd, 64'hDEADBEEF_00000000);

    // halfword store with valid dropped after acceptance
    do_acc(0, BASE + 10, MSIZE2, 8'h0C, 64'h0000_0000_BEEF_0000, 1'b1, acc, ok, rd, e);
    chk("sh_drop_ok_cycle", u64'(ok), 2);
    do_acc(0, BASE + 8, MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("sh_drop_ld", rd, 64'h01020304_BEEF0708);

    // back-to-back loads, valid held throughout
    @(posedge clk); #1;
    drive(0, mk(BASE, MSIZE8, 8'h00, 64'h0));
    st = cyc; nok = 0; sw = 1'b0;
    for (int n = 0; n < 20 && nok < 2; n++) begin
      @(negedge clk);
      if (bus2.dresp.addr_ok) accs.push_back(cyc - st);
      if (bus2.dresp.data_ok) begin nok++; if (nok == 1) sw = 1'b1; end
      @(posedge clk); #1;
      if (sw) begin drive(0, mk(BASE + 8, MSIZE8, 8'h00, 64'h0)); sw = 1'b0; end
    end
    drive(0, '0);
    chk("b2b_data_ok_count", u64'(nok), 2);
    chk("b2b_accept_count", u64'(accs.size()), 2);
    if (accs.size() == 2) chk("b2b_second_accept", u64'(accs[1]), 3);

    // faults
    do_acc(0, 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("flt_low_err", u64'(e), 1);
    chk("flt_low_data", rd, 0);
    do_acc(0, BASE + 64'h8000, MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("flt_high_err", u64'(e), 1);
    do_acc(0, BASE + 3, MSIZE2, 8'h18, 64'h0000_00FF_FF00_0000, 1'b0, acc, ok, rd, e);
    chk("flt_sh_mis_err", u64'(e), 1);
    do_acc(0, BASE + 6, MSIZE4, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("flt_lw_mis_err", u64'(e), 1);
    do_acc(0, BASE, MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("flt_word_unchanged", rd, 64'hDEADBEEF_00000000);
    do_acc(0, BASE + 1, MSIZE1, 8'h02, 64'h0000_0000_0000_AA00, 1'b0, acc, ok, rd, e);
    chk("sb_err", u64'(e), 0);
    do_acc(0, BASE, MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("sb_ld", rd, 64'hDEADBEEF_0000AA00);

    // reset during an accepted store
    @(posedge clk); #1;
    drive(0, mk(BASE, MSIZE8, 8'hFF, 64'h5555_5555_5555_5555));
    @(negedge clk);
    chk("rmid_accept", u64'(bus2.dresp.addr_ok), 1);
    @(posedge clk); #1;
    reset = 1'b1; drive(0, '0);
    @(negedge clk);
    chk("rmid_no_data_ok", u64'(bus2.dresp.data_ok), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, mk(BASE, MSIZE8, 8'h00, 64'h0));
    wait_done(0, 1'b0, acc, ok, rd, e, df);
    chk("rmid_data_zero", df, 0);
    chk("rmid_next_accept", u64'(acc), 0);
    chk("rmid_word_kept", rd, 64'hDEADBEEF_0000AA00);

    // LATENCY=1 build
    do_acc(1, BASE, MSIZE8, 8'h00, 64'h0, 1'b1, acc, ok, rd, e);
    chk("l1_acc_cycle", u64'(acc), 0);
    chk("l1_ok_cycle", u64'(ok), 1);
    chk("l1_data", rd, 64'hCAFEF00D12345678);
    do_acc(1, BASE + 16, MSIZE8, 8'hFF, 64'hA5A5_0F0F_F0F0_5A5A, 1'b1, acc, ok, rd, e);
    do_acc(1, BASE + 16, MSIZE8, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("l1_st_ld", rd, 64'hA5A5_0F0F_F0F0_5A5A);
    do_acc(1, BASE + 2, MSIZE4, 8'h00, 64'h0, 1'b0, acc, ok, rd, e);
    chk("l1_mis_err", u64'(e), 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
